// File: rtl/prot_pkt_tx.sv
// Serial command packet transmitter: frames 0xAA, cmd, len, payload and an XOR checksum
// onto a UART-style line with configurable baud divider, parity and stop bits.
module prot_pkt_tx #(
  parameter int DIV    = 5208,
  parameter int MAXLEN = 8,
  parameter int CMDW   = 4,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic                         ck,
  input  logic                         rstn,
  input  logic [CMDW-1:0]              cmd,
  input  logic [$clog2(MAXLEN+1)-1:0]  len,
  input  logic [8*MAXLEN-1:0]          pld,
  input  logic                         cmd_vld,
  output logic                         cmd_rdy,
  output logic                         tx,
  output logic                         busy,
  output logic                         done,
  output logic                         bit_tick
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAXLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [2:0]          nxt_bit;
  logic                stop_idx;
  logic [8:0]          byte_idx;
  logic [CMDW-1:0]     cmd_q;
  logic [LW-1:0]       len_q;
  logic [8*MAXLEN-1:0] pld_q;
  logic [7:0]          csum;
  logic [7:0]          cur_byte;
  logic                par_bit;
  logic                tx_q;
  logic                tx_n;
  logic                accept;
  logic                stop_last;
  logic                last_byte;
  logic                in_payload;

  assign cmd_rdy    = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = cmd_vld && cmd_rdy;
  assign bit_tick   = busy && (cnt == CNT_LAST);
  assign stop_last  = (STOP == 2) ? stop_idx : 1'b1;
  assign last_byte  = (byte_idx == 9'd3 + 9'(len_q));
  assign in_payload = (byte_idx >= 9'd3) && !last_byte;
  assign done       = bit_tick && (state == S_STOP) && stop_last && last_byte;
  assign nxt_bit    = bit_idx + 3'd1;
  assign tx         = tx_q;

  // Payload bytes are consumed from the top of a shift register, so the
  // current payload byte is always the most significant one.
  always_comb begin
    cur_byte = csum;
    if (byte_idx == 9'd0)
      cur_byte = 8'hAA;
    else if (byte_idx == 9'd1)
      cur_byte = 8'(cmd_q);
    else if (byte_idx == 9'd2)
      cur_byte = 8'(len_q);
    else if (in_payload)
      cur_byte = pld_q[8*MAXLEN-1 -: 8];
  end

  assign par_bit = (PARITY == 2) ? ~(^cur_byte) : ^cur_byte;

  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next state and next line level; tx_n is the level of the bit that starts
  // with the transition, so the line register changes together with the state.
  always_comb begin
    state_n = state;
    tx_n    = tx_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_n = S_DATA;
          tx_n    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              state_n = S_PAR;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n = cur_byte[nxt_bit];
          end
        end
      end
      S_PAR: begin
        if (bit_tick) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick && stop_last) begin
          if (last_byte) begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end else begin
            state_n = S_START;
            tx_n    = 1'b0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      tx_q     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      byte_idx <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      pld_q    <= '0;
      csum     <= '0;
    end else begin
      tx_q <= tx_n;
      if (accept) begin
        cnt      <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        byte_idx <= '0;
        cmd_q    <= cmd;
        len_q    <= (len > LEN_MAX) ? LEN_MAX : len;
        pld_q    <= pld;
        csum     <= '0;
      end else if (busy) begin
        cnt <= bit_tick ? '0 : cnt + CW'(1);
        if (bit_tick) begin
          if (state == S_DATA)
            bit_idx <= nxt_bit;
          // The checksum covers every byte after the sync byte; it is only
          // read while the final byte goes out, after all others were folded in.
          if (state == S_STOP) begin
            if (stop_last) begin
              stop_idx <= 1'b0;
              byte_idx <= byte_idx + 9'd1;
              if (byte_idx != 9'd0)
                csum <= csum ^ cur_byte;
              if (in_payload)
                pld_q <= pld_q << 8;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/prot_pkt_tx.md
Name: prot_pkt_tx

Overview:
Parametrised packet transmitter for the serial command protocol. On an accepted command it frames and sends a header, command, length, variable payload and XOR checksum over a UART-style line. Baud timing, parity and stop-bit count are generic. It feeds the board Tx pin and exports a busy flag and a bit-tick monitor for the LEDs and scope.

Parameters:
DIV, 5208, clock cycles per serial bit (50 MHz / 9600); legal range >= 2
MAXLEN, 8, maximum payload bytes; legal range 1..255
CMDW, 4, command width; legal range 1..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP, 1, stop bits; legal values 1 or 2

Ports:
ck  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
cmd  in  CMDW  command code
len  in  $clog2(MAXLEN+1)  payload byte count
pld  in  8*MAXLEN  payload; byte 0 = pld[8*MAXLEN-1 -: 8]
cmd_vld  in  1  request valid
cmd_rdy  out  1  ready to accept
tx  out  1  serial line, idle high
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of frame
bit_tick  out  1  one-cycle pulse at every bit boundary

Behaviour:
- Clock and reset: one clock, ck. rstn is asynchronous and active-low.
- Reset values: tx=1, cmd_rdy=1, busy=0, done=0, bit_tick=0, state=IDLE, baud counter=0.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), the frame is abandoned and nothing resumes after release.
- Handshake: a command is accepted on a rising ck edge when cmd_vld=1 and cmd_rdy=1.
  - On acceptance, latch cmd, pld and len.
  - If len > MAXLEN, clamp it to MAXLEN.
  - cmd_rdy=0 and busy=1 from the next cycle. cmd_vld is ignored while busy.
- Frame bytes, in order: 0xAA; cmd zero-extended to 8 bits; clamped len zero-extended to 8 bits; len payload bytes (byte 0 first); checksum.
  - checksum = XOR of every byte after 0xAA.
  - Total bytes = 4 + len. len=0 is legal and sends 4 bytes.
- Character format: start bit (0); 8 data bits, LSB first; parity bit if PARITY != 0; STOP stop bits (1).
  - Even parity: parity bit = XOR of the data bits.
  - Odd parity: parity bit = its inverse.
  - Successive bytes follow with no idle gap.
- Baud counter:
  - Counts 0..DIV-1 only while busy.
  - Cleared on acceptance, so tx falls to 0 on the first cycle after the accepting edge.
  - Every bit, start bit included, lasts exactly DIV cycles.
  - bit_tick=1 on the cycle the counter equals DIV-1; it stays 0 in IDLE.
- FSM states: IDLE -> START -> DATA (bit index 0..7) -> PAR (skipped when PARITY=0) -> STOP (STOP bits).
  - After STOP: go to START if bytes remain, otherwise to IDLE.
  - Every state transition occurs only on bit_tick.
- Frame end: on the final stop-bit tick, done=1 for that one cycle, state returns to IDLE, and cmd_rdy=1 and busy=0 from the next cycle.
  - A cmd_vld held high across done is accepted on the first cycle cmd_rdy=1.
- Frame duration: (4+len) * (9 + (PARITY!=0) + STOP) * DIV cycles, measured from the first tx low to done inclusive.
- tx is driven from a register; no combinational path from inputs to tx.

Test Plan:
1. DIV=4, PARITY=0, STOP=1; cmd=9, len=0 -> bytes AA 09 00 09; frame lasts 160 cycles; done pulses once; tx falls exactly 1 cycle after acceptance.
2. cmd=3, len=2, payload AB CD -> bytes AA 03 02 AB CD 67 (checksum 03^02^AB^CD); 6 characters back to back with no idle bits.
3. PARITY=1, then PARITY=2, same stimulus as scenario 1 -> 0xAA parity bit 0 (even) / 1 (odd), 0x09 parity bit 0 (even) / 1 (odd); character length 11 bits. STOP=2 -> two stop-bit periods per character.
4. MAXLEN=8, len=9 -> len byte 0x08; 8 payload bytes sent; checksum computed over the clamped length.
5. Pulse cmd_vld while busy -> ignored, no second frame. Hold cmd_vld across done -> second frame's start bit begins 2 cycles after done.
6. Assert rstn low mid-byte 2 -> tx=1, busy=0, cmd_rdy=1 immediately; after release, the line stays idle until a new command.
